linear_mem_lsu: RTL
===================

Name: linear_mem_lsu

Overview:
- Load/store unit that sits directly upstream of the 16K x 32-bit linear memory macro pair.
- Converts WASM byte-addressed loads and stores into word accesses on the single-port memory interface. Store sizes are 8/16/32 bits; loads add sign or zero extension.
- Handles unaligned accesses that straddle two words, using read-modify-write for partial stores and two reads for straddling loads.
- Raises a trap response for out-of-bounds or illegal-size requests.

Parameters:
- BYTE_AW, 16, byte address width; linear memory is 2^BYTE_AW bytes.
- WORD_AW, 14, word address width; always BYTE_AW-2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_sext  in  1  loads only: sign-extend when 1
- req_addr  in  BYTE_AW  byte address
- req_wdata  in  32  store data, low bytes used
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  32  load result, extended; 0 for stores and traps
- rsp_err  out  1  trap flag, qualified by rsp_valid
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  WORD_AW  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after a read issue

Behaviour:
- Reset: state=IDLE; req_ready=1 once rst falls; every other output 0. A reset mid-operation abandons the access at the next edge: no further mem_en, no response.
- Accept on req_valid&req_ready. Latch we/size/sext/addr/wdata. lo = addr[BYTE_AW-1:2], off = addr[1:0], nbytes = 1/2/4, span = (off+nbytes>4).
- Trap when size==3 or addr+nbytes-1 > 2^BYTE_AW-1. Trap path is IDLE->RESP: rsp_err=1, rsp_rdata=0, no memory access. rsp_valid rises 1 cycle after accept.
- States: IDLE, RD_LO, RD_HI, WAIT, WR_LO, WR_HI, RESP.
- RD_LO: en=1, we=0, addr=lo. Next state is RD_HI if span, else WAIT.
- RD_HI: en=1, we=0, addr=lo+1. Capture mem_rdata into win_lo. Next state WAIT.
- WAIT: en=0. Capture mem_rdata into win_hi if span, else into win_lo. Next state: load -> RESP; store -> WR_LO.
- WR_LO: en=1, we=1, addr=lo, wdata=merged[31:0]. Next state is WR_HI if span, else RESP.
- WR_HI: en=1, we=1, addr=lo+1, wdata=merged[63:32]. Next state RESP.
- Aligned word store (size=2, off=0) bypasses the read path: IDLE->WR_LO, with merged[31:0]=req_wdata.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Data path, little-endian: window = {win_hi, win_lo}, sh = off*8.
  - Load result = (window>>sh) masked to nbytes. Sign bit is bit 8*nbytes-1 when sext=1; zero-extend otherwise.
  - Store: mask = (2^(8*nbytes)-1)<<sh; merged = (window & ~mask) | ((wdata & sizemask)<<sh).
- Latency in cycles from accept edge to rsp_valid:
  - trap: 1
  - aligned word store: 2
  - non-span load: 3
  - span load: 4
  - non-span partial store: 4
  - span store: 6
- lo+1 crossing word 0x1FFF->0x2000 (bank boundary) is legal and needs no special handling. Word lo+1 beyond the top of memory is always trapped before any access.
- req_valid while busy is ignored; the requester must hold it.

Decomposition:
- Shared defines file: size encodings LSU_SZ_B/H/W, state encodings, BYTE_AW/WORD_AW defaults.
- One combinational sub-module, lsu_lane_align: window/off/size/sext/wdata -> load_result, merged. Unit-testable on its own.
- FSM, latches and trap check stay in linear_mem_lsu.

Test Plan:
- Aligned word store 0xDEADBEEF @0x0010, then word load @0x0010 -> mem writes word 4 at accept+1, one cycle, no read. Load rsp_rdata=0xDEADBEEF at accept+3, rsp_err=0.
- Memory word 4 = 0x11223344. Byte store 0xAA @0x0011 -> read word 4, write 0x1122AA44. rsp at accept+4.
- Words 4,5 = 0x44332211, 0x88776655. Half load @0x0013 with sext=1 -> 0x00005544. Same with word 4 = 0xFF332211 -> 0x000055FF. Word 5 = 0x887766CC, sext=1 -> 0xFFFFCCFF. Each rsp at accept+4.
- Span word store 0xA1B2C3D4 @0x7FFE, words 0x1FFF/0x2000 initially 0 -> writes 0xC3D40000 to 0x1FFF and 0x0000A1B2 to 0x2000. rsp at accept+6.
- Two traps: word load @0xFFFE -> rsp_err=1 at accept+1, mem_en never high. size=3 @0x0000 -> rsp_err=1.
- Assert rst during WR_LO of a span store -> no WR_HI write, no rsp_valid. req_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/linear_mem_lsu_pkg.sv
// Shared encodings and helpers for the linear-memory load/store unit.
package linear_mem_lsu_pkg;

  localparam int unsigned LSU_BYTE_AW = 16;
  localparam int unsigned LSU_WORD_AW = LSU_BYTE_AW - 2;

  localparam logic [1:0] LSU_SZ_B = 2'd0;
  localparam logic [1:0] LSU_SZ_H = 2'd1;
  localparam logic [1:0] LSU_SZ_W = 2'd2;
  localparam logic [1:0] LSU_SZ_X = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_HI = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WR_LO = 3'd4;
  localparam logic [2:0] S_WR_HI = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  // Access length in bytes; the illegal size is trapped before this matters.
  function automatic logic [2:0] lsu_nbytes(input logic [1:0] size);
    case (size)
      LSU_SZ_B: lsu_nbytes = 3'd1;
      LSU_SZ_H: lsu_nbytes = 3'd2;
      default:  lsu_nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] lsu_size_mask(input logic [1:0] size);
    case (size)
      LSU_SZ_B: lsu_size_mask = 32'h0000_00FF;
      LSU_SZ_H: lsu_size_mask = 32'h0000_FFFF;
      default:  lsu_size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/linear_mem_lsu_if.sv
// Request/response and memory-port bundle between requester, LSU and memory macro.
interface linear_mem_lsu_if #(
  parameter int unsigned BYTE_AW = 16,
  parameter int unsigned WORD_AW = BYTE_AW - 2
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_sext;
  logic [BYTE_AW-1:0] req_addr;
  logic [31:0]        req_wdata;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               mem_en;
  logic               mem_we;
  logic [WORD_AW-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/linear_mem_lsu_lane_align.sv
// Little-endian byte-lane alignment: load extraction/extension and store merge
// over a two-word window.
module lsu_lane_align
  import linear_mem_lsu_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic [31:0] load_result_c,
  output logic [63:0] merged_c
);
  logic [4:0]  sh;
  logic [31:0] size_mask;
  logic [63:0] shifted;
  logic [31:0] raw;
  logic        sign;
  logic [63:0] lane_mask;

  always_comb begin
    sh        = {off, 3'b000};
    size_mask = lsu_size_mask(size);
    shifted   = window >> sh;
    raw       = shifted[31:0] & size_mask;
    case (size)
      LSU_SZ_B: sign = raw[7];
      LSU_SZ_H: sign = raw[15];
      default:  sign = 1'b0;
    endcase
    load_result_c = (sext && sign) ? (raw | ~size_mask) : raw;
    lane_mask     = {32'h0, size_mask} << sh;
    merged_c      = (window & ~lane_mask) | ({32'h0, wdata & size_mask} << sh);
  end
endmodule

// File: rtl/linear_mem_lsu.sv
// WASM byte-addressed load/store unit in front of the single-port 32-bit
// linear memory; splits straddling accesses and does read-modify-write.
module linear_mem_lsu
  import linear_mem_lsu_pkg::*;
#(
  parameter int unsigned BYTE_AW = LSU_BYTE_AW,
  parameter int unsigned WORD_AW = BYTE_AW - 2
) (
  input logic             clk,
  input logic             rst,
  linear_mem_lsu_if.slave bus
);
  logic [2:0]         state_q, state_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               sext_q, sext_d;
  logic [BYTE_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               span_q, span_d;
  logic [31:0]        win_lo_q, win_lo_d;
  logic [31:0]        win_hi_q, win_hi_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [WORD_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;

  logic               accept;
  logic [BYTE_AW:0]   end_addr;
  logic               trap;
  logic               req_span;
  logic               bypass;
  logic [WORD_AW-1:0] lo;
  logic [WORD_AW-1:0] lo_p1;
  logic [31:0]        load_result_c;
  logic [63:0]        merged_c;

  lsu_lane_align u_align (
    .window        ({win_hi_d, win_lo_d}),
    .off           (addr_q[1:0]),
    .size          (size_q),
    .sext          (sext_q),
    .wdata         (wdata_q),
    .load_result_c (load_result_c),
    .merged_c      (merged_c)
  );

  // Read-data capture window, kept apart so the lane aligner sees this cycle's data.
  always_comb begin
    win_lo_d = win_lo_q;
    win_hi_d = win_hi_q;
    if (state_q == S_RD_HI) begin
      win_lo_d = bus.mem_rdata;
    end else if (state_q == S_WAIT) begin
      if (span_q) win_hi_d = bus.mem_rdata;
      else        win_lo_d = bus.mem_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    span_d      = span_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = 32'h0;

    accept   = bus.req_valid && req_ready_q;
    end_addr = {1'b0, bus.req_addr} + (BYTE_AW+1)'(lsu_nbytes(bus.req_size))
             - (BYTE_AW+1)'(1);
    trap     = (bus.req_size == LSU_SZ_X) || end_addr[BYTE_AW];
    req_span = ({1'b0, bus.req_addr[1:0]} + lsu_nbytes(bus.req_size)) > 3'd4;
    bypass   = bus.req_we && (bus.req_size == LSU_SZ_W) && (bus.req_addr[1:0] == 2'b00);
    lo       = accept ? bus.req_addr[BYTE_AW-1:2] : addr_q[BYTE_AW-1:2];
    lo_p1    = lo + WORD_AW'(1);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          sext_d  = bus.req_sext;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          span_d  = req_span;
          if (trap)        state_d = S_RESP;
          else if (bypass) state_d = S_WR_LO;
          else             state_d = S_RD_LO;
        end
      end
      S_RD_LO: state_d = span_q ? S_RD_HI : S_WAIT;
      S_RD_HI: state_d = S_WAIT;
      S_WAIT:  state_d = we_q ? S_WR_LO : S_RESP;
      S_WR_LO: state_d = span_q ? S_WR_HI : S_RESP;
      S_WR_HI: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in that state.
    case (state_d)
      S_IDLE:  req_ready_d = 1'b1;
      S_RD_LO: begin
        mem_en_d   = 1'b1;
        mem_addr_d = lo;
      end
      S_RD_HI: begin
        mem_en_d   = 1'b1;
        mem_addr_d = lo_p1;
      end
      S_WR_LO: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = lo;
        mem_wdata_d = accept ? bus.req_wdata : merged_c[31:0];
      end
      S_WR_HI: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = lo_p1;
        mem_wdata_d = merged_c[63:32];
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = accept;
        rsp_rdata_d = (!accept && !we_q) ? load_result_c : 32'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      span_q      <= 1'b0;
      win_lo_q    <= 32'h0;
      win_hi_q    <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      span_q      <= span_d;
      win_lo_q    <= win_lo_d;
      win_hi_q    <= win_hi_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
